// File: rtl/aes_req_arbiter.sv
// Round-robin issue arbiter for a shared pipelined AES-128 core, with ownership tag pipe and pause/drain FSM.
// Optional AES_ARB_STATS_EN adds issue/stall counters.
module aes_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [128*NUM_REQ-1:0]   req_key,
  input  logic [128*NUM_REQ-1:0]   req_plaintext,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [127:0]             resp_ciphertext,
  input  logic                     pause,
  output logic                     drained,
  output logic [127:0]             core_key,
  output logic [127:0]             core_plaintext,
  input  logic [127:0]             core_ciphertext
`ifdef AES_ARB_STATS_EN
  ,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stalled
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra stage covers the core_key/core_plaintext register in front of the core.
  localparam int TAG_DEPTH = PIPE_LAT + 1;
  localparam int CNTW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]   ptr, win_id;
  logic             win_found;
  logic [IDW:0]     scan;
  logic             grant_en, issue, retire;
  logic [TAG_DEPTH-1:0] tag_vld;
  logic [IDW-1:0]   tag_id [TAG_DEPTH];
  logic [CNTW-1:0]  inflight, inflight_nxt;

  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!win_found && req_valid[scan[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan[IDW-1:0];
      end
    end
  end

  assign issue        = grant_en && win_found;
  assign retire       = tag_vld[TAG_DEPTH-1];
  assign inflight_nxt = inflight + CNTW'(issue) - CNTW'(retire);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (pause) state_nxt = DRAIN;
      DRAIN:   if (!pause) state_nxt = RUN;
               else if (inflight_nxt == '0) state_nxt = PAUSED;
      PAUSED:  if (!pause) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs; a pause request blocks the grant in the same cycle
  always_comb begin
    grant_en  = (state == RUN) && !pause && !rst;
    req_ready = (grant_en && win_found) ? (NUM_REQ'(1) << win_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      core_key        <= '0;
      core_plaintext  <= '0;
      tag_vld         <= '0;
      inflight        <= '0;
      resp_valid      <= '0;
      resp_ciphertext <= '0;
      drained         <= 1'b0;
      for (int s = 0; s < TAG_DEPTH; s++) tag_id[s] <= '0;
    end else begin
      if (issue) begin
        core_key       <= req_key[128*int'(win_id) +: 128];
        core_plaintext <= req_plaintext[128*int'(win_id) +: 128];
        ptr            <= (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
      end
      tag_vld   <= {tag_vld[TAG_DEPTH-2:0], issue};
      tag_id[0] <= win_id;
      for (int s = 1; s < TAG_DEPTH; s++) tag_id[s] <= tag_id[s-1];
      inflight <= inflight_nxt;
      if (retire) begin
        resp_valid      <= NUM_REQ'(1) << tag_id[TAG_DEPTH-1];
        resp_ciphertext <= core_ciphertext;
      end else begin
        resp_valid      <= '0;
      end
      drained <= (state == PAUSED) && (state_nxt == PAUSED);
    end
  end

`ifdef AES_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_stalled <= '0;
    end else begin
      if (issue) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !issue) stat_stalled <= stat_stalled + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural core stand-in and an issue-order scoreboard.
module tb_aes_req_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int PIPE_LAT = 11;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REQ-1:0] req_valid, req_ready, resp_valid;
  logic [128*NUM_REQ-1:0] req_key, req_plaintext;
  logic [127:0] resp_ciphertext, core_key, core_plaintext, core_ciphertext;
  logic pause, drained;
`ifdef AES_ARB_STATS_EN
  logic [31:0] stat_issued, stat_stalled;
`endif

  logic [127:0] kv [NUM_REQ];
  logic [127:0] pv [NUM_REQ];
  logic [127:0] cpipe [PIPE_LAT];

  typedef struct {
    logic [NUM_REQ-1:0] onehot;
    logic [127:0]       ct;
    int                 cyc;
  } exp_t;
  exp_t sb [$];
  int   grant_log [$];

  int cyc = 0;
  int checks = 0;
  int errs = 0;
  int last_resp_cyc = -1;
  int first_drain;
  logic drained_seen;

  aes_req_arbiter #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_plaintext(req_plaintext),
    .resp_valid(resp_valid), .resp_ciphertext(resp_ciphertext),
    .pause(pause), .drained(drained),
    .core_key(core_key), .core_plaintext(core_plaintext),
    .core_ciphertext(core_ciphertext)
`ifdef AES_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stalled(stat_stalled)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_key = '0;
    req_plaintext = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_key[128*i +: 128]       = kv[i];
      req_plaintext[128*i +: 128] = pv[i];
    end
  end

  // Stand-in cipher: any fixed keyed mixing exposes routing and alignment faults.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    return k ^ {p[95:0], p[127:96]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  always @(posedge clk) begin
    cpipe[0] <= core_f(core_key, core_plaintext);
    for (int s = 1; s < PIPE_LAT; s++) cpipe[s] <= cpipe[s-1];
  end
  assign core_ciphertext = cpipe[PIPE_LAT-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.onehot = NUM_REQ'(1) << i;
          e.ct     = core_f(kv[i], pv[i]);
          e.cyc    = cyc + PIPE_LAT + 2;
          sb.push_back(e);
          grant_log.push_back(i);
        end
      end
    end
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", resp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_owner", resp_valid, e.onehot);
        chk("resp_ct", resp_ciphertext, e.ct);
        chk("resp_cycle", cyc, e.cyc);
        last_resp_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      kv[i] = {32'(i), 32'(cyc), 64'h01234567_89abcdef};
      pv[i] = {64'(cyc * 7 + i), 64'hfeedface_00000000 ^ 64'(i)};
    end
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", 128'(sb.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    pause = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      kv[i] = '0;
      pv[i] = '0;
    end

    // reset state
    step(); step();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_ct", resp_ciphertext, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_pt", core_plaintext, 0);
    chk("rst_drained", drained, 0);
    step();
    rst = 1'b0;
    req_valid = '0;

    // fairness: all requesters valid for 40 cycles
    grant_log.delete();
    for (int n = 0; n < 40; n++) begin
      set_data();
      req_valid = '1;
      step();
    end
    req_valid = '0;
    chk("fair_count", 128'(grant_log.size()), 40);
    for (int n = 0; n < grant_log.size(); n++) chk("fair_order", 128'(grant_log[n]), 128'(n % NUM_REQ));
    wait_empty();

    // single issue from requester 2
    kv[2] = 128'h11111111_11111111_11111111_11111111;
    pv[2] = {64'h0, 64'h11111111_11111111};
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("single_core_key", core_key, 128'h11111111_11111111_11111111_11111111);
    chk("single_core_pt", core_plaintext, {64'h0, 64'h11111111_11111111});
    wait_empty();

    // pause drain: 5 blocks then pause with requests still pending
    for (int n = 0; n < 5; n++) begin
      set_data();
      req_valid = 4'b0001;
      step();
    end
    pause = 1'b1;
    req_valid = '1;
    first_drain = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      chk("pause_no_grant", req_ready, 0);
      if (drained && first_drain < 0) first_drain = cyc;
      step();
    end
    chk("drain_rise_cycle", 128'(first_drain), 128'(last_resp_cyc + 1));
    chk("drain_sb_empty", 128'(sb.size()), 0);
    chk("drain_held", drained, 1);
    pause = 1'b0;
    req_valid = '0;
    step();
    chk("drain_release", drained, 0);

    // pause abort with 8 blocks in flight
    for (int n = 0; n < 8; n++) begin
      set_data();
      req_valid = '1;
      step();
    end
    pause = 1'b1;
    drained_seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_no_grant", req_ready, 0);
      drained_seen |= drained;
      step();
    end
    pause = 1'b0;
    req_valid = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      drained_seen |= drained;
    end
    chk("abort_no_drained", drained_seen, 0);
    wait_empty();

    // reset mid-flight discards 6 blocks
    step();
    for (int n = 0; n < 6; n++) begin
      set_data();
      req_valid = '1;
      step();
    end
    req_valid = '0;
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    for (int n = 0; n < PIPE_LAT + 2; n++) begin
      @(negedge clk);
      chk("rst_flight_quiet", resp_valid, 0);
      step();
    end
    set_data();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    wait_empty();

`ifdef AES_ARB_STATS_EN
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      set_data();
      req_valid = 4'b0001;
      step();
    end
    pause = 1'b1;
    for (int n = 0; n < 4; n++) step();
    req_valid = '0;
    step();
    chk("stat_issued", stat_issued, 10);
    chk("stat_stalled", stat_stalled, 4);
    pause = 1'b0;
    wait_empty();
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
